// File: rtl/inst_axi_rd_bridge.sv
// Instruction-side read bridge: SRAM-like fetch port to single-beat AXI reads.
// Issues one AR per accepted request and returns R data to fetch in issue order.
module inst_axi_rd_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [3:0]  ARID_VAL        = 4'd0
) (
    input  logic        clk,
    input  logic        reset,

    // fetch-side SRAM-like port
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    // AXI AR channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    // AXI R channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic        bus_err
);

    localparam logic [2:0] MaxOut = 3'(MAX_OUTSTANDING);

    logic        arvalid_q, arvalid_d;
    logic [31:0] araddr_q, araddr_d;
    logic [1:0]  arsize_q, arsize_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        bus_err_q, bus_err_d;

    logic can_issue;
    logic addr_ok;
    logic data_ok;

    // Write-side fields, ID and last are meaningless for in-order single-beat reads.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rlast};

    // Handshake decode: a new request may only replace an AR that is leaving this cycle.
    always_comb begin
        can_issue = (cnt_q < MaxOut) & (~arvalid_q | arready);
        addr_ok   = inst_sram_req & ~inst_sram_wr & can_issue;
        rready    = (cnt_q != 3'd0);
        data_ok   = rvalid & rready;
    end

    // Next-state logic for the AR register, outstanding counter and error flag.
    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arsize_d  = arsize_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;

        if (addr_ok) begin
            arvalid_d = 1'b1;
            araddr_d  = inst_sram_addr;
            arsize_d  = inst_sram_size;
        end else if (arvalid_q && arready) begin
            arvalid_d = 1'b0;
        end

        // Accept and return in the same cycle cancel out.
        unique case ({addr_ok, data_ok})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase

        if (data_ok && (rresp != 2'b00)) begin
            bus_err_d = 1'b1;
        end
    end

    // State registers with synchronous reset; an in-flight AR is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            arvalid_q <= 1'b0;
            araddr_q  <= 32'd0;
            arsize_q  <= 2'b10;
            cnt_q     <= 3'd0;
            bus_err_q <= 1'b0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arsize_q  <= arsize_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Output mapping; AR payload comes straight from the held registers.
    always_comb begin
        inst_sram_addr_ok = addr_ok;
        inst_sram_data_ok = data_ok;
        inst_sram_rdata   = rdata;

        arid    = ARID_VAL;
        araddr  = araddr_q;
        arlen   = 8'd0;
        arsize  = {1'b0, arsize_q};
        arburst = 2'b01;
        arlock  = 2'b00;
        arcache = 4'd0;
        arprot  = 3'd0;
        arvalid = arvalid_q;
        bus_err = bus_err_q;
    end

endmodule
